// File: rtl/valu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// valu_ctrl_pkg
// Shared definitions for the VALU issue/writeback sequencer:
//   - valu_ctrl_state_e : sequencer state encoding
//   - VALU_TIMEOUT      : default watchdog limit in WAIT/DRAIN
//   - VALU_DATA_W / VALU_XLEN / VALU_TRANS_ID_BITS : default widths
// -----------------------------------------------------------------------------
package valu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WB    = 3'd3,
        ST_DRAIN = 3'd4
    } valu_ctrl_state_e;

    localparam int unsigned VALU_TIMEOUT       = 64;
    localparam int unsigned VALU_DATA_W        = 32;
    localparam int unsigned VALU_XLEN          = 64;
    localparam int unsigned VALU_TRANS_ID_BITS = 3;

endpackage

// File: rtl/valu_ctrl_wdog.sv
// -----------------------------------------------------------------------------
// valu_ctrl_wdog
// Clearable, saturating watchdog counter used while the sequencer waits on the
// VALU (WAIT) or drains a killed operation (DRAIN).
// Ports:
//   clk_i     in   clock
//   rst_ni    in   asynchronous active-low reset
//   i_clear   in   force count to zero (takes priority over i_enable)
//   i_enable  in   advance count by one
//   o_expire  out  count has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module valu_ctrl_wdog
    import valu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = VALU_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_expire;

    assign w_expire = (r_count == CNT_MAX);
    assign o_expire = w_expire;

    // Count stops at CNT_MAX so a long DRAIN can never wrap back to a
    // non-expired value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: state registers use non-blocking (<=) so every flop samples
            // pre-edge values regardless of statement order.
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_expire) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/valu_ctrl.sv
// -----------------------------------------------------------------------------
// valu_ctrl
// Issue/writeback sequencer for the multi-cycle VALU in the execute stage.
// Accepts one instruction at a time, pulses start to the VALU, waits for done
// under a watchdog, then holds the result until the shared FLU writeback port
// is free. A flush after start drains the in-flight VALU op so its late done
// is never attributed to a later instruction.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   flush_i                       pipeline flush, kills current op
//   issue_valid_i / issue_ready_o issue handshake (ready only in IDLE)
//   operand_a_i, operand_b_i      operands captured at issue
//   trans_id_i                    scoreboard id captured at issue
//   valu_start_o                  one-cycle start pulse to VALU
//   valu_operand_a_o/_b_o         held operands while VALU busy, else 0
//   valu_done_i, valu_result_i    VALU completion pulse and result
//   wb_busy_i                     FLU port taken by higher-priority unit
//   wb_valid_o, wb_trans_id_o     writeback valid and id
//   wb_result_o                   zero-extended result (0 when not valid)
//   wb_timeout_o                  writeback is a watchdog-forced completion
//   busy_o                        sequencer not in IDLE
// -----------------------------------------------------------------------------
module valu_ctrl
    import valu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W        = VALU_DATA_W,
    parameter int unsigned XLEN          = VALU_XLEN,
    parameter int unsigned TRANS_ID_BITS = VALU_TRANS_ID_BITS,
    parameter int unsigned TIMEOUT       = VALU_TIMEOUT
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic [DATA_W-1:0]        operand_a_i,
    input  logic [DATA_W-1:0]        operand_b_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     valu_start_o,
    output logic [DATA_W-1:0]        valu_operand_a_o,
    output logic [DATA_W-1:0]        valu_operand_b_o,
    input  logic                     valu_done_i,
    input  logic [DATA_W-1:0]        valu_result_i,
    input  logic                     wb_busy_i,
    output logic                     wb_valid_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [XLEN-1:0]          wb_result_o,
    output logic                     wb_timeout_o,
    output logic                     busy_o
);

    valu_ctrl_state_e r_state;
    valu_ctrl_state_e w_state_next;

    logic [DATA_W-1:0]        r_op_a;
    logic [DATA_W-1:0]        r_op_b;
    logic [TRANS_ID_BITS-1:0] r_trans_id;
    logic [DATA_W-1:0]        r_result;
    logic                     r_timeout;

    logic w_issue_ready;
    logic w_start;
    logic w_wb_valid;
    logic w_expire;
    logic w_wdog_clear;
    logic w_wdog_enable;
    logic w_hold_ops;
    logic w_accept;

    // ------------------------------------------------------------------
    // Watchdog: zeroed in START so the WAIT window always begins at 0;
    // keeps counting through DRAIN from wherever WAIT left it.
    // ------------------------------------------------------------------
    assign w_wdog_clear  = (r_state == ST_START);
    assign w_wdog_enable = (r_state == ST_WAIT) || (r_state == ST_DRAIN);

    valu_ctrl_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_clear  (w_wdog_clear),
        .i_enable (w_wdog_enable),
        .o_expire (w_expire)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        w_state_next  = r_state;
        w_issue_ready = 1'b0;
        w_start       = 1'b0;
        w_wb_valid    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_issue_ready = 1'b1;
                if (issue_valid_i && !flush_i) begin
                    w_state_next = ST_START;
                end
            end

            // A flush here kills the op before the VALU ever sees a start,
            // so there is nothing to drain.
            ST_START: begin
                w_start      = !flush_i;
                w_state_next = flush_i ? ST_IDLE : ST_WAIT;
            end

            // Flush wins over done/expiry. If done coincides with the flush
            // the VALU is already quiet and DRAIN can be skipped.
            ST_WAIT: begin
                if (flush_i) begin
                    w_state_next = valu_done_i ? ST_IDLE : ST_DRAIN;
                end else if (valu_done_i || w_expire) begin
                    w_state_next = ST_WB;
                end
            end

            ST_WB: begin
                w_wb_valid = !wb_busy_i && !flush_i;
                if (w_wb_valid || flush_i) begin
                    w_state_next = ST_IDLE;
                end
            end

            // Further flushes are irrelevant: the op is already dead.
            ST_DRAIN: begin
                if (valu_done_i || w_expire) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand / id / result capture
    // ------------------------------------------------------------------
    assign w_accept = (r_state == ST_IDLE) && issue_valid_i && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_trans_id <= '0;
            r_result   <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op_a     <= operand_a_i;
                r_op_b     <= operand_b_i;
                r_trans_id <= trans_id_i;
            end
            // Done takes precedence over expiry when both land in the last
            // WAIT cycle: a real result beats a forced one.
            if ((r_state == ST_WAIT) && !flush_i) begin
                if (valu_done_i) begin
                    r_result  <= valu_result_i;
                    r_timeout <= 1'b0;
                end else if (w_expire) begin
                    r_result  <= '0;
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs; data buses are forced to zero whenever they are not valid
    // to avoid toggling downstream logic.
    // ------------------------------------------------------------------
    assign w_hold_ops = (r_state == ST_START) || (r_state == ST_WAIT) ||
                        (r_state == ST_DRAIN);

    assign issue_ready_o    = w_issue_ready;
    assign valu_start_o     = w_start;
    assign valu_operand_a_o = w_hold_ops ? r_op_a : '0;
    assign valu_operand_b_o = w_hold_ops ? r_op_b : '0;
    assign wb_valid_o       = w_wb_valid;
    assign wb_trans_id_o    = w_wb_valid ? r_trans_id : '0;
    assign wb_result_o      = w_wb_valid ? XLEN'(r_result) : '0;
    assign wb_timeout_o     = w_wb_valid && r_timeout;
    assign busy_o           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_valu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_valu_ctrl
// Self-checking bench for valu_ctrl. Expected behaviour of each transaction is
// derived from its done latency and writeback back-pressure with plain
// arithmetic: the writeback cycle, its payload and the issue/busy windows.
// -----------------------------------------------------------------------------
module tb_valu_ctrl;

    localparam int DW  = 32;
    localparam int XL  = 64;
    localparam int IDW = 3;
    localparam int T   = 8;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           flush_i;
    logic           issue_valid_i;
    logic           issue_ready_o;
    logic [DW-1:0]  operand_a_i;
    logic [DW-1:0]  operand_b_i;
    logic [IDW-1:0] trans_id_i;
    logic           valu_start_o;
    logic [DW-1:0]  valu_operand_a_o;
    logic [DW-1:0]  valu_operand_b_o;
    logic           valu_done_i;
    logic [DW-1:0]  valu_result_i;
    logic           wb_busy_i;
    logic           wb_valid_o;
    logic [IDW-1:0] wb_trans_id_o;
    logic [XL-1:0]  wb_result_o;
    logic           wb_timeout_o;
    logic           busy_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    valu_ctrl #(
        .DATA_W        (DW),
        .XLEN          (XL),
        .TRANS_ID_BITS (IDW),
        .TIMEOUT       (T)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .issue_valid_i    (issue_valid_i),
        .issue_ready_o    (issue_ready_o),
        .operand_a_i      (operand_a_i),
        .operand_b_i      (operand_b_i),
        .trans_id_i       (trans_id_i),
        .valu_start_o     (valu_start_o),
        .valu_operand_a_o (valu_operand_a_o),
        .valu_operand_b_o (valu_operand_b_o),
        .valu_done_i      (valu_done_i),
        .valu_result_i    (valu_result_i),
        .wb_busy_i        (wb_busy_i),
        .wb_valid_o       (wb_valid_o),
        .wb_trans_id_o    (wb_trans_id_o),
        .wb_result_o      (wb_result_o),
        .wb_timeout_o     (wb_timeout_o),
        .busy_o           (busy_o)
    );

    // Hard stop in case something never returns.
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    task automatic clear_inputs();
        flush_i       = 1'b0;
        issue_valid_i = 1'b0;
        operand_a_i   = '0;
        operand_b_i   = '0;
        trans_id_i    = '0;
        valu_done_i   = 1'b0;
        valu_result_i = '0;
        wb_busy_i     = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Control flags packed as {issue_ready, start, busy, wb_valid}.
    task automatic check_ctrl(input string name, input int c, input logic [3:0] exp);
        logic [3:0] got;
        got = {issue_ready_o, valu_start_o, busy_o, wb_valid_o};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d ctrl{ready,start,busy,wbv}: got %b expected %b", name, c, got, exp);
        end
    endtask

    // One full transaction issued in the current cycle (c=0, DUT in IDLE).
    // lat   : cycles from start to done (0 = VALU never answers)
    // nbusy : cycles the FLU port is claimed once the result is ready
    task automatic run_op(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [IDW-1:0] id, input int lat, input logic [DW-1:0] res,
                          input int nbusy, input bit hold_valid, input bit noise);
        bit             exp_to;
        int             wb_first;
        int             wb_cyc;
        logic [XL-1:0]  exp_res;
        logic [67:0]    exp_wb;
        logic [67:0]    got_wb;
        logic [63:0]    exp_ops;
        logic [63:0]    got_ops;
        // Done later than the last WAIT cycle is equivalent to no done at all.
        exp_to   = (lat == 0) || (lat > T);
        exp_res  = exp_to ? '0 : XL'(res);
        wb_first = 2 + (exp_to ? T : lat);
        wb_cyc   = wb_first + nbusy;
        for (int c = 0; c <= wb_cyc + 1; c++) begin
            flush_i       = 1'b0;
            issue_valid_i = (c == 0) || (hold_valid && c <= wb_cyc);
            operand_a_i   = a;
            operand_b_i   = b;
            trans_id_i    = id;
            valu_done_i   = !exp_to && (c == 1 + lat);
            valu_result_i = valu_done_i ? res : DW'($urandom);
            if (c >= wb_first && c < wb_cyc)
                wb_busy_i = 1'b1;
            else if (c < wb_first && noise)
                wb_busy_i = 1'($urandom_range(0, 1));
            else
                wb_busy_i = 1'b0;
            @(negedge clk_i);
            check_ctrl(name, c, {(c == 0) || (c == wb_cyc + 1), c == 1,
                                 (c >= 1) && (c <= wb_cyc), c == wb_cyc});
            exp_ops = (c >= 1 && c < wb_first) ? {a, b} : 64'd0;
            got_ops = {valu_operand_a_o, valu_operand_b_o};
            checks++;
            if (got_ops !== exp_ops) begin
                errors++;
                $display("FAIL %s cycle %0d operands: got %h expected %h", name, c, got_ops, exp_ops);
            end
            exp_wb = (c == wb_cyc) ? {exp_to, id, exp_res} : 68'd0;
            got_wb = {wb_timeout_o, wb_trans_id_o, wb_result_o};
            checks++;
            if (got_wb !== exp_wb) begin
                errors++;
                $display("FAIL %s cycle %0d wb{timeout,id,result}: got %h expected %h", name, c, got_wb, exp_wb);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_ni = 1'b0;
        #12;
        check_ctrl("reset_hold", 0, 4'b1000);
        checks++;
        if ({valu_operand_a_o, valu_operand_b_o, wb_trans_id_o, wb_result_o, wb_timeout_o} !== '0) begin
            errors++;
            $display("FAIL reset_data: got nonzero data outputs, expected all zero");
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        next_cycle();
        @(negedge clk_i);
        check_ctrl("reset_release", 0, 4'b1000);
        next_cycle();
    endtask

    task automatic test_basic();
        run_op("basic", 32'd5, 32'd7, 3'd2, 1, 32'd12, 0, 1'b0, 1'b0);
    endtask

    task automatic test_contention();
        run_op("contention", 32'd5, 32'd7, 3'd2, 1, 32'd12, 3, 1'b0, 1'b0);
    endtask

    task automatic test_done_boundary();
        run_op("done_last_wait", 32'h11, 32'h22, 3'd6, T, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
        run_op("done_too_late", 32'h33, 32'h44, 3'd7, T + 1, 32'h1234_5678, 1, 1'b0, 1'b0);
    endtask

    task automatic test_watchdog();
        run_op("watchdog", 32'h9, 32'hA, 3'd5, 0, 32'hABCD, 0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            check_ctrl("watchdog_after", c, 4'b1000);
            next_cycle();
        end
    endtask

    task automatic test_flush_wait();
        for (int c = 0; c <= 6; c++) begin
            clear_inputs();
            issue_valid_i = (c == 0);
            operand_a_i   = 32'hA5A5_0001;
            operand_b_i   = 32'h5A5A_0002;
            trans_id_i    = 3'd1;
            flush_i       = (c == 2);
            valu_done_i   = (c == 5);
            valu_result_i = 32'hDEAD;
            @(negedge clk_i);
            check_ctrl("flush_wait", c, {c == 0 || c == 6, c == 1, c >= 1 && c <= 5, 1'b0});
            if (c >= 3 && c <= 5) begin
                checks++;
                if ({valu_operand_a_o, valu_operand_b_o} !== {32'hA5A5_0001, 32'h5A5A_0002}) begin
                    errors++;
                    $display("FAIL flush_wait_drain_ops cycle %0d: got %h_%h expected a5a50001_5a5a0002",
                             c, valu_operand_a_o, valu_operand_b_o);
                end
            end
            next_cycle();
        end
        clear_inputs();
        run_op("after_flush", 32'd100, 32'd23, 3'd4, 2, 32'd123, 0, 1'b0, 1'b0);
    endtask

    // Flushed op whose VALU never answers: must leave DRAIN on the watchdog.
    task automatic test_drain_timeout();
        int  c;
        bit  seen_wb;
        bit  returned;
        seen_wb  = 1'b0;
        returned = 1'b0;
        c        = 0;
        while (c < 2 * T + 6 && !returned) begin
            clear_inputs();
            issue_valid_i = (c == 0);
            trans_id_i    = 3'd3;
            flush_i       = (c == 2) || (c == 4);
            @(negedge clk_i);
            if (wb_valid_o) seen_wb = 1'b1;
            if (c > 2 && !busy_o) returned = 1'b1;
            c++;
            next_cycle();
        end
        checks++;
        if (!returned || seen_wb) begin
            errors++;
            $display("FAIL drain_timeout: returned=%0b wb_seen=%0b, expected returned=1 wb_seen=0", returned, seen_wb);
        end
        checks++;
        if (returned && (c - 1 > T + 3)) begin
            errors++;
            $display("FAIL drain_timeout_len: idle at cycle %0d, expected by cycle %0d", c - 1, T + 3);
        end
        clear_inputs();
    endtask

    task automatic test_flush_wb();
        for (int c = 0; c <= 5; c++) begin
            clear_inputs();
            issue_valid_i = (c == 0);
            trans_id_i    = 3'd2;
            valu_done_i   = (c == 2);
            valu_result_i = 32'h77;
            wb_busy_i     = (c == 3);
            flush_i       = (c == 4);
            @(negedge clk_i);
            check_ctrl("flush_wb", c, {c == 0 || c == 5, c == 1, c >= 1 && c <= 4, 1'b0});
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_flush_start();
        for (int c = 0; c <= 4; c++) begin
            clear_inputs();
            issue_valid_i = (c == 0);
            operand_a_i   = 32'h1;
            trans_id_i    = 3'd6;
            flush_i       = (c == 1);
            @(negedge clk_i);
            check_ctrl("flush_start", c, {c != 1, 1'b0, c == 1, 1'b0});
            next_cycle();
        end
        // Issue together with flush in IDLE is dropped.
        clear_inputs();
        issue_valid_i = 1'b1;
        flush_i       = 1'b1;
        next_cycle();
        clear_inputs();
        @(negedge clk_i);
        check_ctrl("flush_idle", 0, 4'b1000);
        next_cycle();
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            clear_inputs();
            issue_valid_i = (c == 0);
            operand_a_i   = 32'hFFFF_0000;
            trans_id_i    = 3'd5;
            if (c < 2) next_cycle();
        end
        // Now in WAIT; pull reset asynchronously mid-cycle.
        #2;
        rst_ni = 1'b0;
        #1;
        check_ctrl("reset_mid_async", 0, 4'b1000);
        checks++;
        if (valu_operand_a_o !== '0) begin
            errors++;
            $display("FAIL reset_mid_ops: got %h expected 0", valu_operand_a_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            valu_done_i   = (c == 0);
            valu_result_i = 32'hBAD0_BAD0;
            @(negedge clk_i);
            check_ctrl("reset_mid_stray_done", c, 4'b1000);
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        run_op("b2b_first", 32'h10, 32'h20, 3'd1, 3, 32'h30, 1, 1'b1, 1'b0);
        run_op("b2b_second", 32'h40, 32'h50, 3'd2, 1, 32'h90, 0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_op("random", DW'($urandom), DW'($urandom), IDW'($urandom_range(0, 7)),
                   $urandom_range(0, T + 2), DW'($urandom), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_contention();
        test_done_boundary();
        test_watchdog();
        test_flush_wait();
        test_drain_timeout();
        test_flush_wb();
        test_flush_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
